// File: rtl/wb_irq_ctrl.sv
// Wishbone-slave interrupt controller: synchronises N_IRQ device lines, latches them
// per channel in edge or level mode, and presents a masked, prioritised INT/CAUSE.
module wb_irq_ctrl #(
  parameter int          N_IRQ      = 8,
  parameter logic [31:0] CAUSE_BASE = 32'h0
) (
  input  logic             clk,
  input  logic             RSTN,
  input  logic             STB,
  input  logic             WE,
  input  logic [31:0]      ADDR,
  input  logic [31:0]      DAT_I,
  output logic [31:0]      DAT_O,
  output logic             ACK,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  typedef enum logic [1:0] {IDLE, ACKS, HOLD} bus_state_t;

  bus_state_t       state;
  logic [N_IRQ-1:0] s1, s2, s3;
  logic [N_IRQ-1:0] pending, mask, mode;
  logic [N_IRQ-1:0] wdat, w1c, force_set, rise, act;
  logic [2:0]       word;
  logic             wr;
  logic [31:0]      rd_data, winner;
  logic             unused_ok;

  assign word      = ADDR[4:2];
  assign wdat      = DAT_I[N_IRQ-1:0];
  assign wr        = (state == IDLE) && STB && WE;
  assign w1c       = (wr && word == 3'd0) ? wdat : '0;
  assign force_set = (wr && word == 3'd5) ? wdat : '0;
  assign rise      = s2 & ~s3;
  assign act       = pending & mask;
  assign unused_ok = ^{ADDR[31:5], ADDR[1:0], DAT_I};

  always_comb begin
    rd_data = '0;
    case (word)
      3'd0:    rd_data = 32'(pending);
      3'd1:    rd_data = 32'(mask);
      3'd2:    rd_data = 32'(mode);
      3'd3:    rd_data = {INT, CAUSE[30:0]};
      3'd4:    rd_data = 32'(s2);
      default: rd_data = '0;
    endcase
  end

  // Scan downwards so the lowest active index is the one left standing.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (act[i]) winner = 32'(i);
    end
  end

  // Edge channels: a rise or FORCE sets, W1C clears, set beats clear.
  // Level channels simply follow the synchronised line.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      pending <= '0;
      INT     <= 1'b0;
      CAUSE   <= '0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      s3      <= s2;
      pending <= (mode & ((pending & ~w1c) | rise | force_set)) | (~mode & s2);
      INT     <= |act;
      CAUSE   <= (|act) ? CAUSE_BASE + winner : '0;
    end
  end

  // One ACK and one write commit per strobe; HOLD waits for the master to release STB.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state <= IDLE;
      ACK   <= 1'b0;
      DAT_O <= '0;
      mask  <= '0;
      mode  <= '0;
    end else begin
      case (state)
        IDLE: begin
          ACK <= 1'b0;
          if (STB) begin
            state <= ACKS;
            ACK   <= 1'b1;
            DAT_O <= rd_data;
            if (WE) begin
              if (word == 3'd1) mask <= wdat;
              if (word == 3'd2) mode <= wdat;
            end
          end
        end
        ACKS: begin
          ACK   <= 1'b0;
          state <= HOLD;
        end
        HOLD: begin
          ACK <= 1'b0;
          if (!STB) state <= IDLE;
        end
        default: begin
          ACK   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_irq_ctrl.sv
// Self-checking bench for wb_irq_ctrl: register vectors through a read scoreboard,
// then hand-built sequences for interrupt latency, priority, masking and bus corners.
module tb_wb_irq_ctrl;

  localparam int          N_IRQ      = 8;
  localparam logic [31:0] CAUSE_BASE = 32'h10;

  logic             clk;
  logic             rstn;
  logic             stb;
  logic             we;
  logic [31:0]      addr;
  logic [31:0]      dat_i;
  logic [31:0]      dat_o;
  logic             ack;
  logic [N_IRQ-1:0] irq_in;
  logic             int_o;
  logic [31:0]      cause;

  wb_irq_ctrl #(.N_IRQ(N_IRQ), .CAUSE_BASE(CAUSE_BASE)) dut (
    .clk(clk), .RSTN(rstn), .STB(stb), .WE(we), .ADDR(addr), .DAT_I(dat_i),
    .DAT_O(dat_o), .ACK(ack), .irq_in(irq_in), .INT(int_o), .CAUSE(cause)
  );

  typedef struct {
    logic        we;
    logic [2:0]  word;
    logic [31:0] wdata;
    logic [31:0] expected;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          ack_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] wordAddr(input logic [2:0] word);
    logic [26:0] hi;
    logic [1:0]  lo;
    hi = 27'($urandom);
    lo = 2'($urandom);
    return {hi, word, lo};
  endfunction

  function automatic vec_t mkVec(input logic w, input logic [2:0] word, input logic [31:0] wdata,
                                 input logic [31:0] expected);
    vec_t v;
    v.we = w; v.word = word; v.wdata = wdata; v.expected = expected;
    return v;
  endfunction

  // Lets the FSM pass through ACKS and HOLD back to IDLE with STB low.
  task automatic endAccess();
    tick();
    tick();
  endtask

  // Drives one write strobe; returns just after the committing edge.
  task automatic busWrite(input logic [2:0] word, input logic [31:0] data);
    addr  = wordAddr(word);
    dat_i = data;
    we    = 1'b1;
    stb   = 1'b1;
    tick();
    stb = 1'b0;
    we  = 1'b0;
    checkOutput("wr_ack", 32'(ack), 32'd1);
  endtask

  task automatic writeReg(input logic [2:0] word, input logic [31:0] data);
    busWrite(word, data);
    endAccess();
  endtask

  task automatic busRead(input logic [2:0] word, input logic [31:0] expected);
    logic got_ack;
    sb_q.push_back(expected);
    addr  = wordAddr(word);
    dat_i = 32'($urandom);
    we    = 1'b0;
    stb   = 1'b1;
    tick();
    stb = 1'b0;
    got_ack = 1'b0;
    for (int c = 0; c < 3 && !got_ack; c++) begin
      if (ack) got_ack = 1'b1;
      else tick();
    end
    if (got_ack) begin
      checkOutput($sformatf("rd_word%0d", word), dat_o, sb_q.pop_front());
    end else begin
      checkOutput("rd_ack_timeout", 32'(ack), 32'd1);
      void'(sb_q.pop_front());
    end
    endAccess();
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.we) writeReg(v.word, v.wdata);
    else      busRead(v.word, v.expected);
  endtask

  initial begin
    rstn   = 1'b0;
    stb    = 1'b0;
    we     = 1'b0;
    addr   = '0;
    dat_i  = '0;
    irq_in = '0;
    tick();
    tick();
    checkOutput("rst_int", 32'(int_o), 32'd0);
    checkOutput("rst_cause", cause, 32'd0);
    checkOutput("rst_ack", 32'(ack), 32'd0);
    checkOutput("rst_dat_o", dat_o, 32'd0);
    rstn = 1'b1;
    tick();

    // Reset contents of every word, then basic register behaviour.
    for (int w = 0; w < 8; w++) vecs.push_back(mkVec(1'b0, 3'(w), 32'h0, 32'h0));
    vecs.push_back(mkVec(1'b1, 3'd1, 32'hFFFF_FFA5, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'd1, 32'h0, 32'h0000_00A5));
    vecs.push_back(mkVec(1'b1, 3'd2, 32'h0000_013C, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'd2, 32'h0, 32'h0000_003C));
    vecs.push_back(mkVec(1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'd6, 32'h0, 32'h0));
    vecs.push_back(mkVec(1'b1, 3'd7, 32'hFFFF_FFFF, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'd7, 32'h0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'd5, 32'h0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'd0, 32'h0, 32'h0));
    vecs.push_back(mkVec(1'b0, 3'd3, 32'h0, 32'h0));
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset asserted while the FSM sits in HOLD with STB still high.
    addr = wordAddr(3'd2);
    we   = 1'b0;
    stb  = 1'b1;
    tick();
    checkOutput("hold_ack", 32'(ack), 32'd1);
    checkOutput("hold_dat_o", dat_o, 32'h0000_003C);
    tick();
    rstn = 1'b0;
    #1;
    checkOutput("midrst_ack", 32'(ack), 32'd0);
    checkOutput("midrst_dat_o", dat_o, 32'd0);
    tick();
    checkOutput("midrst_ack2", 32'(ack), 32'd0);
    stb = 1'b0;
    rstn = 1'b1;
    tick();
    busRead(3'd2, 32'h0);
    busRead(3'd1, 32'h0);

    // Edge mode latency and W1C.
    writeReg(3'd2, 32'hFF);
    writeReg(3'd1, 32'hFF);
    irq_in[5] = 1'b1;
    tick();
    tick();
    irq_in[5] = 1'b0;
    tick();
    checkOutput("edge_int_e3", 32'(int_o), 32'd0);
    tick();
    checkOutput("edge_int_e4", 32'(int_o), 32'd1);
    checkOutput("edge_cause", cause, 32'h15);
    busRead(3'd0, 32'h20);
    busRead(3'd3, 32'h8000_0015);
    busWrite(3'd0, 32'h20);
    checkOutput("w1c_int_k", 32'(int_o), 32'd1);
    tick();
    checkOutput("w1c_int_k1", 32'(int_o), 32'd0);
    checkOutput("w1c_cause_k1", cause, 32'h0);
    tick();

    // Priority between channels 6 and 2.
    irq_in = 8'h44;
    tick();
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    checkOutput("prio_cause", cause, 32'h12);
    writeReg(3'd0, 32'h04);
    checkOutput("prio_cause_after_clr", cause, 32'h16);
    writeReg(3'd0, 32'h40);
    checkOutput("prio_int_cleared", 32'(int_o), 32'd0);

    // Masking a pending channel, then re-enabling it.
    irq_in[2] = 1'b1;
    tick();
    tick();
    irq_in[2] = 1'b0;
    tick();
    tick();
    checkOutput("mask_int_pre", 32'(int_o), 32'd1);
    writeReg(3'd1, 32'hFB);
    checkOutput("mask_int_off", 32'(int_o), 32'd0);
    checkOutput("mask_cause_off", cause, 32'h0);
    busRead(3'd0, 32'h04);
    busWrite(3'd1, 32'hFF);
    checkOutput("unmask_int_k", 32'(int_o), 32'd0);
    tick();
    checkOutput("unmask_int_k1", 32'(int_o), 32'd1);
    checkOutput("unmask_cause_k1", cause, 32'h12);
    tick();
    writeReg(3'd0, 32'h04);

    // Level mode ignores W1C and FORCE and follows the line.
    writeReg(3'd2, 32'h00);
    irq_in[3] = 1'b1;
    tick();
    tick();
    tick();
    tick();
    checkOutput("level_int", 32'(int_o), 32'd1);
    checkOutput("level_cause", cause, 32'h13);
    writeReg(3'd0, 32'h08);
    writeReg(3'd5, 32'h08);
    busRead(3'd0, 32'h08);
    busRead(3'd4, 32'h08);
    irq_in[3] = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("level_int_e3", 32'(int_o), 32'd1);
    tick();
    checkOutput("level_int_e4", 32'(int_o), 32'd0);

    // W1C committed on the very edge that sees the rise: set wins.
    writeReg(3'd2, 32'hFF);
    irq_in[1] = 1'b1;
    tick();
    tick();
    busWrite(3'd0, 32'h02);
    endAccess();
    busRead(3'd0, 32'h02);
    irq_in[1] = 1'b0;
    writeReg(3'd0, 32'h02);
    busRead(3'd0, 32'h00);

    // A strobe held for ten cycles gives one ACK and one FORCE commit.
    ack_count = 0;
    addr  = wordAddr(3'd5);
    dat_i = 32'h01;
    we    = 1'b1;
    stb   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (ack) ack_count++;
    end
    stb = 1'b0;
    we  = 1'b0;
    tick();
    if (ack) ack_count++;
    tick();
    checkOutput("long_stb_acks", 32'(ack_count), 32'd1);
    busRead(3'd0, 32'h01);
    checkOutput("force_cause", cause, 32'h10);

    checkOutput("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errors);
    $finish;
  end

endmodule
